// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving a CPU core and an ADC DMA writer shared access to one
// native-protocol memory port, with a bus timeout so a silent slave cannot hang either master.
module mem_bus_arbiter #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                TIMEOUT   = 64,
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                m0_valid,
  input  logic                m0_instr,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,

  input  logic                m1_valid,
  input  logic                m1_instr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,

  output logic                s_valid,
  output logic                s_instr,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,

  output logic [1:0]          grant,
  output logic                timeout_err
);

  // A disabled timeout still keeps a one-bit counter so the widths stay legal.
  localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               lastGrant_q, lastGrant_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;

  logic               owner1;
  logic               granted;
  logic               selValid;
  logic               selInstr;
  logic [ADDR_W-1:0]  selAddr;
  logic [DATA_W-1:0]  selWdata;
  logic [DATA_W/8-1:0] selWstrb;
  logic               timeoutHit;
  logic               xferReady;
  logic [DATA_W-1:0]  xferRdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      waitCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      waitCnt_q   <= waitCnt_d;
    end
  end

  assign owner1   = (state_q == GNT1);
  assign granted  = (state_q != IDLE);
  assign selValid = owner1 ? m1_valid : m0_valid;
  assign selInstr = owner1 ? m1_instr : m0_instr;
  assign selAddr  = owner1 ? m1_addr  : m0_addr;
  assign selWdata = owner1 ? m1_wdata : m0_wdata;
  assign selWstrb = owner1 ? m1_wstrb : m0_wstrb;

  // The timeout fires on the cycle the counter sits at TIMEOUT-1, so s_valid is seen TIMEOUT-1 times.
  assign timeoutHit = (TIMEOUT != 0) && granted && selValid && !s_ready
                      && (waitCnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    waitCnt_d   = waitCnt_q;
    s_valid     = 1'b0;
    s_instr     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    grant       = 2'b00;
    xferReady   = 1'b0;
    xferRdata   = '0;
    timeout_err = 1'b0;

    case (state_q)
      IDLE: begin
        waitCnt_d = '0;
        if (m0_valid && m1_valid) begin
          if (lastGrant_q) begin
            state_d     = GNT0;
            lastGrant_d = 1'b0;
          end else begin
            state_d     = GNT1;
            lastGrant_d = 1'b1;
          end
        end else if (m0_valid) begin
          state_d     = GNT0;
          lastGrant_d = 1'b0;
        end else if (m1_valid) begin
          state_d     = GNT1;
          lastGrant_d = 1'b1;
        end
      end

      GNT0, GNT1: begin
        grant   = owner1 ? 2'b10 : 2'b01;
        s_valid = selValid && !timeoutHit;
        s_instr = selInstr;
        s_addr  = selAddr;
        s_wdata = selWdata;
        s_wstrb = selWstrb;
        if (!selValid) begin
          state_d = IDLE;
        end else if (s_ready) begin
          xferReady = 1'b1;
          xferRdata = s_rdata;
          state_d   = IDLE;
        end else if (timeoutHit) begin
          xferReady   = 1'b1;
          xferRdata   = ERR_RDATA;
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else if (waitCnt_q != CNT_MAX) begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m0_ready = xferReady && !owner1;
  assign m1_ready = xferReady && owner1;
  assign m0_rdata = m0_ready ? xferRdata : '0;
  assign m1_rdata = m1_ready ? xferRdata : '0;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-requester arbiter sharing one native-protocol memory port (valid/ready/addr/wdata/wstrb/rdata, picorv32 style) between master 0 (CPU core) and master 1 (ADC sample DMA writer). It sits between the requesters and the single on-chip RAM/ROM model. Arbitration is round-robin with a bus timeout, so a silent slave cannot hang the CPU.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; wstrb width is DATA_W/8
TIMEOUT, 64, max cycles a granted transfer waits for s_ready; 0 disables the timeout
ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out transfer

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
m0_valid  in  1  master 0 request
m0_instr  in  1  master 0 instruction-fetch flag
m0_addr  in  ADDR_W  master 0 byte address
m0_wdata  in  DATA_W  master 0 write data
m0_wstrb  in  DATA_W/8  master 0 byte strobes; 0 means read
m0_ready  out  1  master 0 transfer complete
m0_rdata  out  DATA_W  master 0 read data
m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  same as m0_*, for master 1
s_valid  out  1  request to slave
s_instr  out  1  forwarded instr flag
s_addr  out  ADDR_W  forwarded address
s_wdata  out  DATA_W  forwarded write data
s_wstrb  out  DATA_W/8  forwarded strobes
s_ready  in  1  slave completion
s_rdata  in  DATA_W  slave read data
grant  out  2  one-hot current owner; 00 when idle
timeout_err  out  1  one-cycle pulse on timeout

Behaviour:
- Protocol: a master holds valid, addr, wdata and wstrb stable until it sees ready=1 for one cycle, then deasserts valid in the next cycle. rdata is valid only while ready=1.
- FSM states: IDLE, GNT0, GNT1. Registered state, last_grant bit, and a wait counter of clog2(TIMEOUT+1) bits.
- IDLE:
  - Only m0_valid set -> GNT0. Only m1_valid set -> GNT1.
  - Both set -> grant the master that is not last_grant.
  - Neither set -> stay in IDLE.
  - On any grant, last_grant is updated and the counter is cleared.
- GNTx, outputs:
  - s_valid = mx_valid.
  - s_instr, s_addr, s_wdata and s_wstrb are muxed combinationally from master x.
  - grant = one-hot x.
- GNTx, completion: when s_ready=1, mx_ready=1 and mx_rdata=s_rdata in the same cycle, then the FSM goes to IDLE.
- GNTx, waiting: when s_ready=0, the counter increments.
- GNTx, timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT-1 with s_ready still 0:
  - mx_ready=1, mx_rdata=ERR_RDATA, timeout_err=1 for that cycle.
  - s_valid is forced to 0 in that cycle. A write is dropped.
  - FSM goes to IDLE.
- GNTx, protocol violation: if mx_valid drops while granted, go to IDLE. No ready is issued and no error is raised.
- Non-granted master: its ready is 0 and its rdata is 0. Both masters' rdata are 0 whenever their ready is 0.
- Latency: a request in IDLE at cycle N is granted and presented on s_valid at N+1. With a slave registered one cycle, ready arrives at N+2.
- One mandatory IDLE cycle separates consecutive transfers; it absorbs the requester's valid deassertion. Back-to-back requests from both masters alternate 0,1,0,1.
- s_ready while in IDLE is ignored.
- Reset (resetn=0 at a clk edge):
  - state=IDLE, last_grant=1 (so m0 wins the first tie), counter=0.
  - All outputs 0: s_valid, grant, mx_ready, mx_rdata, timeout_err.
  - Reset mid-transfer abandons the transfer without issuing ready.
- The counter saturates and does not wrap. With TIMEOUT=0 it never triggers.

Test Plan:
- Single read, m0: m0 reads 0x0 with mem[0]=0x00A00093 and a 1-cycle registered slave -> s_valid at N+1, m0_ready and m0_rdata=0x00A00093 at N+2, grant=01 then 00.
- Single write, m1: m1 writes 0x40, wdata=30, wstrb=1111 -> s_wstrb=1111, s_addr=0x40, m1_ready pulses once, mem[16]=30, m0_ready stays 0.
- Contention: m0 and m1 request together from reset and both re-request continuously for 4 transfers -> grant order 01,10,01,10, each separated by one idle cycle.
- Timeout: TIMEOUT=8 and the slave never asserts ready -> s_valid is high for 7 cycles, then m0_ready=1, m0_rdata=0xDEADBEEF, timeout_err pulses once, s_valid=0 in that cycle.
- Reset mid-transfer: assert resetn=0 while in GNT1 with s_ready low -> the next cycle shows s_valid=0, grant=00, m1_ready=0; the first tie after reset goes to m0.
- Valid drop: m0 deasserts valid during GNT0 -> returns to IDLE, no m0_ready, no timeout_err, and a pending m1 is granted next.
